// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI4 memory responder.
//   resp_t  : AXI response codes used on B and R.
//   state_t : responder FSM states.
//   LFSR_*  : stall generator seed and feedback taps (x^16 + x^14 + x^13 + x^11 + 1).
package axi_mem_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_DATA
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 map to bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
//   clk, rst_n : clock, asynchronous active-low reset (read register only)
//   we, be     : write enable and byte enables for the addressed word
//   re         : read enable; rdata updates the cycle after re
//   addr       : word index, depth 2^MEM_AW
//   wdata      : write data
//   rdata      : registered read data, holds its value while re=0
module axi_mem_ram
  import axi_mem_pkg::*;
#(
  parameter int MEM_AW = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  re,
  input  logic [MEM_AW-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset branch so it maps onto RAM macros; contents
  // survive a reset and start undefined.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: INCR bursts on AW/W/B and AR/R, one transaction at a
// time, backed by a 2^MEM_AW-word RAM with byte strobes.
//   CLK, RST          : clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*   : write address, data and response channels
//   s_axi_ar*/r*      : read address and data channels
// Optional: define AXI_MEM_RESPONDER_STALL_EN to insert pseudo-random stalls
// from a 16-bit LFSR (ready forced low, new valids delayed while lfsr[0]=1).
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  state_t              state_q, state_d;
  logic                favour_rd_q, favour_rd_d;
  logic [MEM_AW-1:0]   idx_q, idx_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                awready_q, awready_d;
  logic                arready_q, arready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  resp_t               bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic                rd_need_q, rd_need_d;

  logic                stall;
  logic                aw_hs, ar_hs, w_hs, r_hs;
  logic                w_final, w_mismatch, rd_want;
  logic                ram_we, ram_re;
  logic [DATA_W-1:0]   ram_rdata;

`ifdef AXI_MEM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = lfsr_next(lfsr_q);
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign s_axi_awready = awready_q & ~stall;
  assign s_axi_arready = arready_q & ~stall;
  assign s_axi_wready  = wready_q & ~stall;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = OKAY;
  assign s_axi_rdata   = ram_rdata;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign r_hs  = rvalid_q & s_axi_rready;

  // The burst length, not wlast, decides where a write burst ends.
  assign w_final    = (cnt_q == len_q);
  assign w_mismatch = (s_axi_wlast != w_final);

  always_comb begin
    // NOTE: every _d starts from its _q so no branch of the case infers a latch.
    state_d     = state_q;
    favour_rd_d = favour_rd_q;
    idx_d       = idx_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    awready_d   = awready_q & ~aw_hs;
    arready_d   = arready_q & ~ar_hs;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rd_need_d   = rd_need_q;
    rd_want     = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (s_axi_arvalid && (!s_axi_awvalid || favour_rd_q)) begin
          arready_d = 1'b1;
          idx_d     = s_axi_araddr[MEM_AW+1:2];
          len_d     = s_axi_arlen;
          cnt_d     = '0;
          state_d   = ST_RD_DATA;
          if (s_axi_awvalid) favour_rd_d = 1'b0;
        end else if (s_axi_awvalid) begin
          awready_d = 1'b1;
          wready_d  = 1'b1;
          idx_d     = s_axi_awaddr[MEM_AW+1:2];
          len_d     = s_axi_awlen;
          cnt_d     = '0;
          err_d     = 1'b0;
          state_d   = ST_WR_DATA;
          if (s_axi_arvalid) favour_rd_d = 1'b1;
        end
      end

      ST_WR_DATA: begin
        if (w_hs) begin
          ram_we = 1'b1;
          err_d  = err_q | w_mismatch;
          if (w_final) begin
            wready_d = 1'b0;
            state_d  = ST_WR_RESP;
            if (!stall) begin
              bvalid_d = 1'b1;
              bresp_d  = (err_q | w_mismatch) ? SLVERR : OKAY;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      ST_WR_RESP: begin
        if (!bvalid_q) begin
          if (!stall) begin
            bvalid_d = 1'b1;
            bresp_d  = err_q ? SLVERR : OKAY;
          end
        end else if (s_axi_bready) begin
          bvalid_d = 1'b0;
          bresp_d  = OKAY;
          err_d    = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      ST_RD_DATA: begin
        // A read is owed after the AR handshake and after each non-last beat
        // is taken; a stall just carries the debt into the next cycle.
        rd_want   = rd_need_q | ar_hs | (r_hs & ~rlast_q);
        ram_re    = rd_want & ~stall;
        rd_need_d = rd_want & stall;
        if (ram_re) begin
          rvalid_d = 1'b1;
          rlast_d  = (cnt_q == len_q);
          cnt_d    = cnt_q + 8'd1;
          idx_d    = idx_q + 1'b1;
        end else if (r_hs) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values computed above.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      favour_rd_q <= 1'b1;
      idx_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      awready_q   <= 1'b0;
      arready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= OKAY;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rd_need_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      favour_rd_q <= favour_rd_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      awready_q   <= awready_d;
      arready_q   <= arready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rd_need_q   <= rd_need_d;
    end
  end

  axi_mem_ram #(
    .MEM_AW (MEM_AW),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (CLK),
    .rst_n (RST),
    .we    (ram_we),
    .be    (s_axi_wstrb),
    .re    (ram_re),
    .addr  (idx_q),
    .wdata (s_axi_wdata),
    .rdata (ram_rdata)
  );

  // Address bits outside the word index are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr[ADDR_W-1:MEM_AW+2], s_axi_awaddr[1:0],
                       s_axi_araddr[ADDR_W-1:MEM_AW+2], s_axi_araddr[1:0]};

endmodule
